vec_checker: RTL and testbench

VEC_CHECKER -- requirements
Module: vec_checker

---
 rtl/vec_checker_if.sv | 22 ++
 rtl/vec_checker.sv | 129 ++++++++++++
 tb/tb_vec_checker.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_checker_if.sv
// Expected-vector stream and observed-sample bus between a stimulus source and vec_checker.
interface vec_checker_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             exp_valid;
  logic             exp_ready;
  logic [WIDTH-1:0] exp_data;
  logic [WIDTH-1:0] exp_mask;
  logic             exp_last;
  logic             act_valid;
  logic [WIDTH-1:0] act_data;

  modport master (
    output exp_valid, exp_data, exp_mask, exp_last, act_valid, act_data,
    input  exp_ready
  );

  modport slave (
    input  exp_valid, exp_data, exp_mask, exp_last, act_valid, act_data,
    output exp_ready
  );
endinterface

// File: rtl/vec_checker.sv
// Queues masked expected vectors and compares them in order against observed samples,
// counting compared, failed and unexpected samples and capturing the first failure.
module vec_checker #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  vec_checker_if.slave     bus,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] unexp_cnt,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_act,
  output logic             err_flag,
  output logic             done
);

  localparam int unsigned AW   = $clog2(DEPTH);
  localparam int unsigned PtrW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [WIDTH-1:0] mask_mem [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q, level;
  logic             full, empty, active, push, pop, unexp, mismatch;
  logic [WIDTH-1:0] head_data, head_mask;

  logic [CNT_W-1:0] vec_cnt_q, err_cnt_q, unexp_cnt_q, first_idx_q;
  logic [WIDTH-1:0] first_exp_q, first_act_q;
  logic             err_flag_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Extra pointer bit separates full from empty.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == PtrW'(DEPTH));
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign head_data = data_mem[rd_ptr_q[AW-1:0]];
  assign head_mask = mask_mem[rd_ptr_q[AW-1:0]];

  assign active        = (state_q == StRun) || (state_q == StDrain);
  assign bus.exp_ready = (state_q == StRun) && !full;
  assign push          = bus.exp_valid && bus.exp_ready;
  // Emptiness is judged before any same-cycle push: no bypass path.
  assign pop           = bus.act_valid && active && !empty;
  assign unexp         = bus.act_valid && active && empty;
  assign mismatch      = pop && (|((bus.act_data ^ head_data) & head_mask));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StRun;
      StRun: begin
        if (start)                    state_d = StRun;
        else if (push && bus.exp_last) state_d = StDrain;
      end
      StDrain: begin
        if (start)                                      state_d = StRun;
        else if (empty || (pop && level == PtrW'(1)))   state_d = StDone;
      end
      StDone:  if (start) state_d = StRun;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr_q[AW-1:0]] <= bus.exp_data;
      mask_mem[wr_ptr_q[AW-1:0]] <= bus.exp_mask;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vec_cnt_q   <= '0;
      err_cnt_q   <= '0;
      unexp_cnt_q <= '0;
      first_idx_q <= '0;
      first_exp_q <= '0;
      first_act_q <= '0;
      err_flag_q  <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) begin
        rd_ptr_q  <= rd_ptr_q + PtrW'(1);
        vec_cnt_q <= sat_inc(vec_cnt_q);
      end
      if (mismatch) begin
        err_cnt_q  <= sat_inc(err_cnt_q);
        err_flag_q <= 1'b1;
        if (err_cnt_q == '0) begin
          first_idx_q <= vec_cnt_q;
          first_exp_q <= head_data;
          first_act_q <= bus.act_data;
        end
      end
      if (unexp) begin
        unexp_cnt_q <= sat_inc(unexp_cnt_q);
        err_flag_q  <= 1'b1;
      end
    end
  end

  assign vec_cnt       = vec_cnt_q;
  assign err_cnt       = err_cnt_q;
  assign unexp_cnt     = unexp_cnt_q;
  assign first_err_idx = first_idx_q;
  assign first_err_exp = first_exp_q;
  assign first_err_act = first_act_q;
  assign err_flag      = err_flag_q;
  assign done          = (state_q == StDone);

endmodule

// File: tb/tb_vec_checker.sv
// Directed and randomized checks of vec_checker against a queue-based reference model;
// a CNT_W=3 copy mirrors the same stimulus to exercise counter saturation.
module tb_vec_checker;
  localparam int W = 4;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst, start;
  always #5 clk = ~clk;

  vec_checker_if #(.WIDTH(W)) b0 ();
  vec_checker_if #(.WIDTH(W)) b1 ();

  assign b1.exp_valid = b0.exp_valid;
  assign b1.exp_data  = b0.exp_data;
  assign b1.exp_mask  = b0.exp_mask;
  assign b1.exp_last  = b0.exp_last;
  assign b1.act_valid = b0.act_valid;
  assign b1.act_data  = b0.act_data;

  logic [15:0]  v0, e0, u0, i0;
  logic [2:0]   v1, e1, u1, i1;
  logic [W-1:0] fe0, fa0, fe1, fa1;
  logic         ef0, dn0, ef1, dn1;

  vec_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(16)) dut0 (
    .clk(clk), .rst(rst), .start(start), .bus(b0),
    .vec_cnt(v0), .err_cnt(e0), .unexp_cnt(u0), .first_err_idx(i0),
    .first_err_exp(fe0), .first_err_act(fa0), .err_flag(ef0), .done(dn0)
  );

  vec_checker #(.WIDTH(W), .DEPTH(D), .CNT_W(3)) dut1 (
    .clk(clk), .rst(rst), .start(start), .bus(b1),
    .vec_cnt(v1), .err_cnt(e1), .unexp_cnt(u1), .first_err_idx(i1),
    .first_err_exp(fe1), .first_err_act(fa1), .err_flag(ef1), .done(dn1)
  );

  typedef struct {
    logic [W-1:0] d;
    logic [W-1:0] m;
  } ent_t;

  // Reference model: phase 0 idle, 1 run, 2 drain, 3 done.
  ent_t         q[$];
  int           m_vec, m_err, m_unexp, m_idx, phase;
  logic [W-1:0] m_fexp, m_fact;
  bit           m_flag;

  int total  = 0;
  int passes = 0;

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
  endtask

  task automatic model_clear(input int ph);
    q.delete();
    m_vec = 0; m_err = 0; m_unexp = 0; m_idx = 0;
    m_fexp = '0; m_fact = '0; m_flag = 0; phase = ph;
  endtask

  function automatic bit model_ready();
    return (phase == 1) && (q.size() < D);
  endfunction

  task automatic model_step();
    bit   was_drain, rdy;
    ent_t e;
    if (start) begin
      model_clear(1);
    end else if (phase == 1 || phase == 2) begin
      was_drain = (phase == 2);
      rdy       = model_ready();
      if (b0.act_valid) begin
        if (q.size() == 0) begin
          m_unexp++;
          m_flag = 1;
        end else begin
          e = q.pop_front();
          if (((b0.act_data ^ e.d) & e.m) != 0) begin
            if (m_err == 0) begin
              m_idx = m_vec; m_fexp = e.d; m_fact = b0.act_data;
            end
            m_err++;
            m_flag = 1;
          end
          m_vec++;
        end
      end
      if (b0.exp_valid && rdy) begin
        e.d = b0.exp_data; e.m = b0.exp_mask;
        q.push_back(e);
        if (b0.exp_last) phase = 2;
      end
      if (was_drain && q.size() == 0) phase = 3;
    end
  endtask

  task automatic check_outputs();
    chk("vec_cnt",       v0,  sat(m_vec, 65535));
    chk("err_cnt",       e0,  sat(m_err, 65535));
    chk("unexp_cnt",     u0,  sat(m_unexp, 65535));
    chk("first_err_idx", i0,  sat(m_idx, 65535));
    chk("first_err_exp", fe0, m_fexp);
    chk("first_err_act", fa0, m_fact);
    chk("err_flag",      ef0, m_flag);
    chk("done",          dn0, phase == 3);
    chk("vec_cnt_w3",    v1,  sat(m_vec, 7));
    chk("err_cnt_w3",    e1,  sat(m_err, 7));
    chk("unexp_cnt_w3",  u1,  sat(m_unexp, 7));
    chk("first_idx_w3",  i1,  sat(m_idx, 7));
    chk("first_exp_w3",  fe1, m_fexp);
    chk("first_act_w3",  fa1, m_fact);
    chk("err_flag_w3",   ef1, m_flag);
    chk("done_w3",       dn1, phase == 3);
  endtask

  // One clock: drive at negedge, check exp_ready, advance the model, check #1 after posedge.
  task automatic step(input bit st, input bit ev, input logic [W-1:0] ed, input logic [W-1:0] em,
                      input bit el, input bit av, input logic [W-1:0] ad);
    @(negedge clk);
    start = st;
    b0.exp_valid = ev; b0.exp_data = ed; b0.exp_mask = em; b0.exp_last = el;
    b0.act_valid = av; b0.act_data = ad;
    #1;
    chk("exp_ready",    b0.exp_ready, model_ready());
    chk("exp_ready_w3", b1.exp_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic do_start();
    step(1, 0, '0, '0, 0, 0, '0);
  endtask

  function automatic logic [W-1:0] head_d();
    logic [W-1:0] h;
    h = (q.size() > 0) ? q[0].d : '0;
    return h;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] ad, ed, em;
    int           target, acc;
    bit           ev, el, av;

    rst = 1'b1; start = 1'b0;
    b0.exp_valid = 0; b0.exp_data = '0; b0.exp_mask = '0; b0.exp_last = 0;
    b0.act_valid = 0; b0.act_data = '0;
    model_clear(0);
    #2;
    check_outputs();
    chk("rst_exp_ready", b0.exp_ready, 0);
    @(negedge clk);
    rst = 1'b0;

    // Three matching vectors, last on the third.
    do_start();
    step(0, 1, 4'h3, 4'hF, 0, 0, '0);
    step(0, 1, 4'h5, 4'hF, 0, 0, '0);
    step(0, 1, 4'h9, 4'hF, 1, 0, '0);
    step(0, 0, '0, '0, 0, 1, 4'h3);
    step(0, 0, '0, '0, 0, 1, 4'h5);
    chk("t1_not_done_yet", dn0, 0);
    step(0, 0, '0, '0, 0, 1, 4'h9);
    chk("t1_vec", v0, 3);
    chk("t1_err", e0, 0);
    chk("t1_flag", ef0, 0);
    chk("t1_done", dn0, 1);
    step(0, 0, '0, '0, 0, 1, 4'h0);
    chk("t1_done_ignores_act", v0, 3);

    // Mask handling.
    do_start();
    step(0, 1, 4'b1010, 4'b1100, 1, 0, '0);
    step(0, 0, '0, '0, 0, 1, 4'b1001);
    chk("t2_masked_err", e0, 0);
    do_start();
    step(0, 1, 4'b1010, 4'b1111, 1, 0, '0);
    step(0, 0, '0, '0, 0, 1, 4'b1001);
    chk("t2_err", e0, 1);
    chk("t2_idx", i0, 0);
    chk("t2_fexp", fe0, 4'b1010);
    chk("t2_fact", fa0, 4'b1001);

    // Fill to full, then pop while offering.
    do_start();
    for (int i = 0; i < 10; i++) step(0, 1, 4'(i), 4'hF, 0, 0, '0);
    chk("t3_full_ready", b0.exp_ready, 0);
    step(0, 1, 4'hE, 4'hF, 0, 1, head_d());
    chk("t3_ready_after_pop", b0.exp_ready, 1);
    step(0, 1, 4'hE, 4'hF, 0, 1, head_d());
    chk("t3_ready_pushpop", b0.exp_ready, 1);
    step(0, 1, 4'hD, 4'hF, 1, 0, '0);
    chk("t3_ready_full_again", b0.exp_ready, 0);
    for (int i = 0; i < 20 && q.size() > 0; i++) step(0, 0, '0, '0, 0, 1, head_d());
    chk("t3_done", dn0, 1);
    chk("t3_vec", v0, 10);
    chk("t3_err", e0, 0);

    // Sample on empty FIFO with a simultaneous push.
    do_start();
    step(0, 1, 4'h6, 4'hF, 1, 1, 4'h6);
    chk("t4_unexp", u0, 1);
    chk("t4_vec", v0, 0);
    chk("t4_flag", ef0, 1);
    step(0, 0, '0, '0, 0, 1, 4'h6);
    chk("t4_queued_vec", v0, 1);
    chk("t4_queued_err", e0, 0);

    // Mismatches at 2 and 5, then async reset while draining.
    do_start();
    for (int i = 0; i < 8; i++) step(0, 1, 4'(i), 4'hF, i == 7, 0, '0);
    for (int k = 0; k < 6; k++) begin
      ad = head_d();
      if (k == 2 || k == 5) ad = ~ad;
      step(0, 0, '0, '0, 0, 1, ad);
    end
    chk("t5_err", e0, 2);
    chk("t5_idx", i0, 2);
    chk("t5_not_done", dn0, 0);
    @(negedge clk);
    b0.exp_valid = 0; b0.act_valid = 0;
    #2 rst = 1'b1;
    #1;
    model_clear(0);
    check_outputs();
    chk("t5_rst_ready", b0.exp_ready, 0);
    #1 rst = 1'b0;
    step(0, 1, 4'h1, 4'hF, 0, 1, 4'h2);
    step(0, 1, 4'h1, 4'hF, 1, 1, 4'h2);
    chk("t5_idle_ready", b0.exp_ready, 0);
    chk("t5_idle_vec", v0, 0);
    chk("t5_idle_unexp", u0, 0);

    // Nine mismatching samples: the CNT_W=3 copy must saturate at 7.
    do_start();
    for (int i = 0; i < 9; i++) step(0, 1, 4'(i), 4'hF, i == 8, i > 0, ~head_d());
    step(0, 0, '0, '0, 0, 1, ~head_d());
    chk("t6_vec16", v0, 9);
    chk("t6_err16", e0, 9);
    chk("t6_sat_vec", v1, 7);
    chk("t6_sat_err", e1, 7);
    chk("t6_sat_done", dn1, 1);

    // Randomized runs, with occasional restarts mid-run.
    for (int r = 0; r < 20; r++) begin
      do_start();
      target = $urandom_range(1, 14);
      acc = 0;
      for (int c = 0; c < 250 && phase != 3; c++) begin
        if ($urandom_range(0, 60) == 0) begin
          do_start();
          acc = 0;
        end else begin
          ev = 1'($urandom_range(0, 1));
          el = (acc + 1 >= target);
          ed = 4'($urandom);
          em = 4'($urandom);
          av = ($urandom_range(0, 2) == 0);
          ad = ($urandom_range(0, 1) == 1) ? head_d() : 4'($urandom);
          if (ev && model_ready()) acc++;
          step(0, ev, ed, em, el, av, ad);
        end
      end
      chk("rand_run_done", dn0, 1);
      step(0, 1, 4'($urandom), 4'hF, 0, 1, 4'($urandom));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
